// File: rtl/bram_sp.sv
`default_nettype none
// ============================================================================
// Module   : bram_sp
// Brief    : Single-port block RAM, write-first, registered read data.
//            Optional second output stage via macro BRAM_OUT_REG_EN.
// Revision : 1.0
// ============================================================================
module bram_sp #(
    parameter int    MEMORY_DEPTH = 4096,
    parameter int    DATA_WIDTH   = 16,
    parameter string INIT_FILE    = "",
    localparam int   AW           = (MEMORY_DEPTH > 1) ? $clog2(MEMORY_DEPTH) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr,
    input  logic [AW-1:0]         address,
    input  logic [DATA_WIDTH-1:0] data,
    output logic [DATA_WIDTH-1:0] q
);

    // One extra bit so the depth itself fits when it is a power of two.
    localparam logic [AW:0] c_DEPTH = (AW+1)'(MEMORY_DEPTH);

    logic [DATA_WIDTH-1:0] r_mem [MEMORY_DEPTH];
    logic [DATA_WIDTH-1:0] r_q;
    logic                  w_inRange;
    logic                  w_wrEn;
    logic [DATA_WIDTH-1:0] w_rdData;

    initial begin
        for (int i = 0; i < MEMORY_DEPTH; i++) r_mem[i] = '0;
    end

    assign w_inRange = ({1'b0, address} < c_DEPTH);
    assign w_wrEn    = wr & w_inRange & ~rst;
    assign w_rdData  = !w_inRange ? '0 : (wr ? data : r_mem[address]);

    // Array kept out of the reset domain so it maps onto device block RAM.
    always_ff @(posedge clk) begin
        if (w_wrEn) begin
            r_mem[address] <= data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q <= '0;
        end else begin
            r_q <= w_rdData;
        end
    end

`ifdef BRAM_OUT_REG_EN
    logic [DATA_WIDTH-1:0] r_q2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q2 <= '0;
        end else begin
            r_q2 <= r_q;
        end
    end

    assign q = r_q2;
`else
    assign q = r_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_bram_sp.sv
`default_nettype none
// ============================================================================
// Module   : tb_bram_sp
// Brief    : Scoreboard bench for bram_sp (depth 3000, non power of two).
// Revision : 1.0
// ============================================================================
module tb_bram_sp;

    localparam int DEPTH = 3000;
    localparam int DW    = 16;
    localparam int AW    = 12;
`ifdef BRAM_OUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr = 1'b0;
    logic [AW-1:0] address = '0;
    logic [DW-1:0] data = '0;
    logic [DW-1:0] q;

    logic [DW-1:0] model [DEPTH];
    logic [DW-1:0] expQ [$];
    int            tagQ [$];
    int            checks = 0;
    int            failures = 0;

    bram_sp #(
        .MEMORY_DEPTH(DEPTH),
        .DATA_WIDTH  (DW),
        .INIT_FILE   ("")
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .wr     (wr),
        .address(address),
        .data   (data),
        .q      (q)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: q=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // One bus cycle: inputs change on negedge, expected response queued for the monitor.
    task automatic access(input int tag, input logic r, input logic w,
                          input logic [AW-1:0] a, input logic [DW-1:0] d);
        logic [DW-1:0] e;
        @(negedge clk);
        wr      = w;
        address = a;
        data    = d;
        if (r && !rst) begin
            rst = 1'b1;
            expQ.delete();
            tagQ.delete();
            for (int k = 0; k < LAT - 1; k++) begin
                expQ.push_back('0);
                tagQ.push_back(tag);
            end
            #1 check("rst_async_clear", q, '0);
        end else begin
            rst = r;
        end
        if (r)                 e = '0;
        else if (int'(a) >= DEPTH) e = '0;
        else if (w) begin
            model[a] = d;
            e = d;
        end else               e = model[a];
        expQ.push_back(e);
        tagQ.push_back(tag);
    endtask

    initial begin : monitor
        logic [DW-1:0] e;
        int            t;
        forever begin
            @(posedge clk);
            #1;
            if (expQ.size() >= LAT) begin
                e = expQ.pop_front();
                t = tagQ.pop_front();
                check($sformatf("q_test%0d", t), q, e);
            end
        end
    end

    initial begin : stimulus
        for (int i = 0; i < DEPTH; i++) model[i] = '0;

        #6 check("reset_q", q, '0);

        access(1, 0, 0, 12'd0, 16'h0000);

        access(2, 0, 1, 12'd5, 16'hABCD);
        access(2, 0, 0, 12'd5, 16'h0000);

        access(3, 0, 1, 12'd0,    16'h1111);
        access(3, 0, 1, 12'd2999, 16'h2222);
        access(3, 0, 0, 12'd2999, 16'h0000);
        access(3, 0, 0, 12'd0,    16'h0000);

        access(4, 0, 1, 12'd10, 16'h5A5A);
        access(4, 0, 0, 12'd10, 16'h0000);
        access(4, 1, 1, 12'd10, 16'hDEAD);
        access(4, 1, 1, 12'd11, 16'hBEEF);
        access(4, 0, 0, 12'd10, 16'h0000);
        access(4, 0, 0, 12'd11, 16'h0000);

        access(5, 0, 1, 12'd1452, 16'h1234);
        access(5, 0, 1, 12'd3500, 16'hFFFF);
        access(5, 0, 0, 12'd1452, 16'h0000);
        access(5, 0, 1, 12'd4095, 16'h7777);
        access(5, 0, 0, 12'd4095, 16'h0000);
        access(5, 0, 0, 12'd3000, 16'h0000);

        access(6, 0, 1, 12'd7, 16'h00C3);
        access(6, 0, 0, 12'd7, 16'h0000);
        access(6, 0, 0, 12'd8, 16'h0000);

        for (int n = 0; n < 600; n++) begin
            logic [AW-1:0] a;
            case ($urandom_range(0, 3))
                0:       a = AW'($urandom_range(0, 15));
                1:       a = AW'($urandom_range(2990, 2999));
                2:       a = AW'($urandom_range(3000, 4095));
                default: a = AW'($urandom_range(0, 4095));
            endcase
            access(7, ($urandom_range(0, 49) == 0), ($urandom_range(0, 1) == 1), a, DW'($urandom));
        end

        repeat (LAT + 1) access(8, 0, 0, 12'd0, 16'h0000);
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
